cgate_hs_source: RTL and testbench

//  Clocked-to-asynchronous bridge that feeds the C-gate (Muller C-element) micropipeline.
//  - Accepts tokens on a synchronous valid/ready port and buffers them in a small FIFO.
//  - Issues each token to the async pipeline with a 4-phase bundled-data handshake (req_out/ack_in).
//  - Counts completed handshakes for observation on the top-level outputs.

---
 rtl/cgate_pkg.sv | 15 +
 rtl/cgate_sync.sv | 28 ++
 rtl/cgate_hs_source.sv | 182 ++++++++++++++++++
 tb/tb_cgate_hs_source.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgate_pkg.sv
// Shared definitions for the C-gate micropipeline source and sink stages.
package cgate_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TOK_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_REQ_HI = 2'd2,
    ST_REQ_LO = 2'd3
  } cgate_state_e;

endpackage

// File: rtl/cgate_sync.sv
// Multi-flop synchroniser for a single asynchronous level; synchronous reset to 0.
module cgate_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/cgate_hs_source.sv
// Clocked valid/ready to 4-phase bundled-data bridge feeding a C-gate micropipeline.
// Optional handshake timeout flag enabled by defining HS_TIMEOUT_EN.
module cgate_hs_source
  import cgate_pkg::*;
#(
  parameter int unsigned WIDTH       = WIDTH_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             busy,
  output logic [TOK_W-1:0] tok_count,
  output logic             err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic ack_s;

  cgate_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ack_in),
    .sync_out (ack_s)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;

  cgate_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             req_q, req_d;
  logic [TOK_W-1:0] tok_q, tok_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic push;
  logic pop;

  assign push = in_valid && in_ready_q;

  // Handshake sequencer; IDLE only launches once the previous ack has fully returned low.
  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    req_d      = req_q;
    tok_d      = tok_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && !ack_s) begin
          data_out_d = mem_q[rd_ptr_q];
          pop        = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        req_d   = 1'b1;
        state_d = ST_REQ_HI;
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_REQ_LO;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          tok_d   = tok_q + TOK_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Token FIFO; simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CNT_W'(DEPTH));
    busy_d     = (count_d != '0) || (state_d != ST_IDLE);
  end

`ifdef HS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter restarts whenever a wait state is entered and saturates at TIMEOUT.
  always_comb begin
    tmo_cnt_d = '0;
    err_d     = err_q;
    if (((state_q == ST_REQ_HI) || (state_q == ST_REQ_LO)) && (state_d == state_q)) begin
      tmo_cnt_d = (tmo_cnt_q == TMO_W'(TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
      if (tmo_cnt_d == TMO_W'(TIMEOUT)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT));

  always_comb begin
    err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      state_q    <= ST_IDLE;
      data_out_q <= '0;
      req_q      <= 1'b0;
      tok_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      state_q    <= state_d;
      data_out_q <= data_out_d;
      req_q      <= req_d;
      tok_q      <= tok_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign data_out  = data_out_q;
  assign req_out   = req_q;
  assign busy      = busy_q;
  assign tok_count = tok_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cgate_hs_source.sv
// Self-checking bench for cgate_hs_source: cycle table for one handshake plus directed corner sequences.
module tb_cgate_hs_source;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       req_out;
  logic       ack_in;
  logic       busy;
  logic [7:0] tok_count;
  logic       err;

  logic model_en;
  logic ack_man;
  logic ack_mdl;
  logic mon_en;

  int errors = 0;
  int checks = 0;

  assign ack_in = model_en ? ack_mdl : ack_man;

  cgate_hs_source #(
    .WIDTH       (8),
    .DEPTH       (4),
    .SYNC_STAGES (2),
    .TIMEOUT     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .req_out   (req_out),
    .ack_in    (ack_in),
    .busy      (busy),
    .tok_count (tok_count),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // C-gate pipeline model: ack follows req with random delays.
  initial begin
    ack_mdl = 1'b0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        ack_mdl = 1'b0;
      end else if (req_out && !ack_mdl) begin
        repeat ($urandom_range(5, 0)) @(negedge clk);
        ack_mdl = 1'b1;
      end else if (!req_out && ack_mdl) begin
        repeat ($urandom_range(5, 0)) @(negedge clk);
        ack_mdl = 1'b0;
      end
    end
  end

  // Reference two-flop synchroniser for ack_in.
  logic s1, s2;
  always @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ack_in;
      s2 <= s1;
    end
  end

  logic       req_prev = 1'b0;
  logic [7:0] dout_prev = 8'h00;
  logic [7:0] seen[$];
  int         rise_bad = 0;
  int         unstable = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_out && !req_prev) begin
        seen.push_back(data_out);
        if (s2) rise_bad++;
      end
      if (req_out && req_prev && (data_out != dout_prev)) unstable++;
    end
    req_prev  <= req_out;
    dout_prev <= data_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_en = 1'b0;
    ack_man  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ack;
    logic       req;
    logic [7:0] dout;
    logic       bsy;
    logic [7:0] tok;
    logic       rdy;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vec [NVEC];

  logic       exp_err;
  logic       rdy;
  logic       acc;
  int         wd;
  int         nacc;
  logic [7:0] nxt;

  initial begin
    // iv, id, ack | req, dout, busy, tok, in_ready  (sampled after each edge)
    vec[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b1};
    vec[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 8'd0, 1'b1};
    vec[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd1, 1'b1};
    vec[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd1, 1'b1};

`ifdef HS_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    mon_en = 1'b0;

    // Reset values
    do_reset();
    chk("rst_req_out", 32'(req_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_tok_count", 32'(tok_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single token 0xA5, full 4-phase handshake cycle by cycle
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      in_valid = vec[i].iv;
      in_data  = vec[i].id;
      ack_man  = vec[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d {req,dout,busy,tok,rdy}", i),
          32'({req_out, data_out, busy, tok_count, in_ready}),
          32'({vec[i].req, vec[i].dout, vec[i].bsy, vec[i].tok, vec[i].rdy}));
    end

    // Capacity with ack stalled low
    do_reset();
    nxt  = 8'h01;
    nacc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = nxt;
      rdy      = in_ready;
      @(posedge clk);
      if (rdy) begin
        nacc++;
        nxt = nxt + 8'd1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("cap_accepted", 32'(nacc), 32'd5);
    chk("cap_in_ready", 32'(in_ready), 32'd0);
    chk("cap_data_out", 32'(data_out), 32'h01);
    chk("cap_req_out", 32'(req_out), 32'd1);
    chk("cap_err", 32'(err), 32'd0);

    // 20 tokens against the random-delay pipeline model
    do_reset();
    model_en = 1'b1;
    mon_en   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(3, 0)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(i);
      acc = 1'b0;
      wd  = 0;
      while (!acc && wd < 500) begin
        rdy = in_ready;
        @(posedge clk);
        acc = rdy;
        wd++;
        @(negedge clk);
      end
      if (!acc) chk($sformatf("stream_push_timeout_%0d", i), 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    wd = 0;
    while (tok_count != 8'd20 && wd < 5000) begin
      @(posedge clk);
      #1;
      wd++;
    end
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("stream_tok_count", 32'(tok_count), 32'd20);
    chk("stream_seen_count", 32'(seen.size()), 32'd20);
    for (int i = 0; i < 20 && i < seen.size(); i++) begin
      chk($sformatf("stream_data_%0d", i), 32'(seen[i]), 32'(i));
    end
    chk("stream_rise_while_ack", 32'(rise_bad), 32'd0);
    chk("stream_data_unstable", 32'(unstable), 32'd0);
    chk("stream_busy_end", 32'(busy), 32'd0);
    model_en = 1'b0;

    // Reset in REQ_HI with ack high, then relaunch only after ack returns low
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h78;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wd = 0;
    while (!req_out && wd < 50) begin
      @(negedge clk);
      wd++;
    end
    chk("rhi_req_before", 32'(req_out), 32'd1);
    ack_man = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rhi_req_after_rst", 32'(req_out), 32'd0);
    chk("rhi_busy_after_rst", 32'(busy), 32'd0);
    chk("rhi_rdy_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rhi_hold_req_%0d", c), 32'(req_out), 32'd0);
    end
    @(negedge clk);
    ack_man = 1'b0;
    @(posedge clk);
    #1;
    chk("rhi_drop_d0", 32'(req_out), 32'd0);
    @(posedge clk);
    #1;
    chk("rhi_drop_d1", 32'(req_out), 32'd0);
    @(posedge clk);
    #1;
    chk("rhi_drop_d2_req", 32'(req_out), 32'd0);
    chk("rhi_drop_d2_data", 32'(data_out), 32'h3C);
    @(posedge clk);
    #1;
    chk("rhi_drop_d3_req", 32'(req_out), 32'd1);

    // Handshake timeout with ack stuck low
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("tmo_req_hi_entry", 32'(req_out), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_err_at_15", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    chk("tmo_err_at_16", 32'(err), 32'(exp_err));
    repeat (10) @(posedge clk);
    #1;
    chk("tmo_err_sticky", 32'(err), 32'(exp_err));
    chk("tmo_req_still_hi", 32'(req_out), 32'd1);
    @(negedge clk);
    do_reset();
    chk("tmo_err_cleared", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
